// File: rtl/l2_msg_sched_if.sv
// Bundled message channels of the L2 message scheduler: request (msg1), forward (msg2),
// response (msg3), line pipeline hand-off and scheduler status.
interface l2_msg_sched_if #(
  parameter int TYPE_W = 8,
  parameter int SRC_W  = 6,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 64
);
  logic              msg1_valid;
  logic              msg1_ready;
  logic [TYPE_W-1:0] msg1_type;
  logic [SRC_W-1:0]  msg1_source;
  logic [TAG_W-1:0]  msg1_tag;
  logic [DATA_W-1:0] msg1_data;

  logic              msg3_valid;
  logic              msg3_ready;
  logic [TYPE_W-1:0] msg3_type;
  logic [SRC_W-1:0]  msg3_source;
  logic [TAG_W-1:0]  msg3_tag;
  logic [DATA_W-1:0] msg3_data;

  logic              pipe_valid;
  logic              pipe_ready;
  logic              pipe_from_resp;
  logic [TYPE_W-1:0] pipe_type;
  logic [SRC_W-1:0]  pipe_source;
  logic [TAG_W-1:0]  pipe_tag;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_fwd_req;
  logic [TYPE_W-1:0] pipe_fwd_type;
  logic [SRC_W-1:0]  pipe_fwd_dest;

  logic              msg2_valid;
  logic              msg2_ready;
  logic [TYPE_W-1:0] msg2_type;
  logic [SRC_W-1:0]  msg2_dest;
  logic [TAG_W-1:0]  msg2_tag;

  logic [1:0]        cur_msg_state;
  logic [TYPE_W-1:0] cur_msg_type;
  logic [SRC_W-1:0]  cur_msg_source;
  logic [TAG_W-1:0]  cur_msg_tag;
  logic [7:0]        ack_wait_cnt;

  modport slave (
    input  msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
    output msg1_ready,
    input  msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
    output msg3_ready,
    output pipe_valid, pipe_from_resp, pipe_type, pipe_source, pipe_tag, pipe_data,
    input  pipe_ready, pipe_fwd_req, pipe_fwd_type, pipe_fwd_dest,
    output msg2_valid, msg2_type, msg2_dest, msg2_tag,
    input  msg2_ready,
    output cur_msg_state, cur_msg_type, cur_msg_source, cur_msg_tag, ack_wait_cnt
  );

  modport master (
    output msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
    input  msg1_ready,
    output msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
    input  msg3_ready,
    input  pipe_valid, pipe_from_resp, pipe_type, pipe_source, pipe_tag, pipe_data,
    output pipe_ready, pipe_fwd_req, pipe_fwd_type, pipe_fwd_dest,
    input  msg2_valid, msg2_type, msg2_dest, msg2_tag,
    output msg2_ready,
    input  cur_msg_state, cur_msg_type, cur_msg_source, cur_msg_tag, ack_wait_cnt
  );
endinterface

// File: rtl/l2_msg_sched.sv
// Single-threaded L2 message scheduler: latches one request/response, issues it to the line
// pipeline, and handles remote-owner forwarding by blocking requests until the owner answers.
module l2_msg_sched #(
  parameter int TYPE_W     = 8,
  parameter int SRC_W      = 6,
  parameter int TAG_W      = 26,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  l2_msg_sched_if.slave  bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_SEND     = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TYPE_W-1:0] cur_type_q, cur_type_d;
  logic [SRC_W-1:0]  cur_src_q, cur_src_d;
  logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
  logic [DATA_W-1:0] cur_data_q, cur_data_d;
  logic              from_resp_q, from_resp_d;
  logic              pipe_valid_q, pipe_valid_d;
  logic              msg2_valid_q, msg2_valid_d;
  logic [TYPE_W-1:0] msg2_type_q, msg2_type_d;
  logic [SRC_W-1:0]  msg2_dest_q, msg2_dest_d;
  logic [TAG_W-1:0]  msg2_tag_q, msg2_tag_d;
  logic [7:0]        ack_cnt_q, ack_cnt_d;
  logic              msg1_ready_s, msg3_ready_s;
  logic              acc1_s, acc3_s;

  // Readies: msg3 normally wins, but is held off once requests have lost STARVE_MAX times
  // so a forced msg1 win never silently swallows a response.
  always_comb begin
    msg1_ready_s = 1'b0;
    msg3_ready_s = 1'b0;
    if (!rst) begin
      msg1_ready_s = 1'b0;
      msg3_ready_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          msg1_ready_s = !(bus.msg3_valid && (starve_q < STARVE_LIM));
          msg3_ready_s = !(bus.msg1_valid && (starve_q >= STARVE_LIM));
        end
        ST_WAIT_ACK: begin
          msg1_ready_s = 1'b0;
          msg3_ready_s = 1'b1;
        end
        default: begin
          msg1_ready_s = 1'b0;
          msg3_ready_s = 1'b0;
        end
      endcase
    end
  end

  assign acc1_s = bus.msg1_valid && msg1_ready_s;
  assign acc3_s = bus.msg3_valid && msg3_ready_s;

  // Next-state and datapath for the in-flight message.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    cur_type_d  = cur_type_q;
    cur_src_d   = cur_src_q;
    cur_tag_d   = cur_tag_q;
    cur_data_d  = cur_data_q;
    from_resp_d = from_resp_q;
    msg2_type_d = msg2_type_q;
    msg2_dest_d = msg2_dest_q;
    msg2_tag_d  = msg2_tag_q;
    ack_cnt_d   = ack_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (acc1_s) begin
          cur_type_d  = bus.msg1_type;
          cur_src_d   = bus.msg1_source;
          cur_tag_d   = bus.msg1_tag;
          cur_data_d  = bus.msg1_data;
          from_resp_d = 1'b0;
          starve_d    = '0;
          state_d     = ST_ISSUE;
        end else if (acc3_s) begin
          cur_type_d  = bus.msg3_type;
          cur_src_d   = bus.msg3_source;
          cur_tag_d   = bus.msg3_tag;
          cur_data_d  = bus.msg3_data;
          from_resp_d = 1'b1;
          state_d     = ST_ISSUE;
          if (bus.msg1_valid && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.pipe_ready) begin
          if (!from_resp_q && bus.pipe_fwd_req) begin
            msg2_type_d = bus.pipe_fwd_type;
            msg2_dest_d = bus.pipe_fwd_dest;
            msg2_tag_d  = cur_tag_q;
            state_d     = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_SEND: begin
        if (bus.msg2_ready) begin
          ack_cnt_d = 8'd0;
          state_d   = ST_WAIT_ACK;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_cnt_q != 8'hFF) begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end else begin
          ack_cnt_d = ack_cnt_q;
        end
        if (acc3_s) begin
          cur_type_d  = bus.msg3_type;
          cur_src_d   = bus.msg3_source;
          cur_tag_d   = bus.msg3_tag;
          cur_data_d  = bus.msg3_data;
          from_resp_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pipe_valid_d = (state_d == ST_ISSUE);
    msg2_valid_d = (state_d == ST_SEND);
  end

  // State and output registers; reset drops any in-flight message.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      starve_q     <= '0;
      cur_type_q   <= '0;
      cur_src_q    <= '0;
      cur_tag_q    <= '0;
      cur_data_q   <= '0;
      from_resp_q  <= 1'b0;
      pipe_valid_q <= 1'b0;
      msg2_valid_q <= 1'b0;
      msg2_type_q  <= '0;
      msg2_dest_q  <= '0;
      msg2_tag_q   <= '0;
      ack_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      cur_type_q   <= cur_type_d;
      cur_src_q    <= cur_src_d;
      cur_tag_q    <= cur_tag_d;
      cur_data_q   <= cur_data_d;
      from_resp_q  <= from_resp_d;
      pipe_valid_q <= pipe_valid_d;
      msg2_valid_q <= msg2_valid_d;
      msg2_type_q  <= msg2_type_d;
      msg2_dest_q  <= msg2_dest_d;
      msg2_tag_q   <= msg2_tag_d;
      ack_cnt_q    <= ack_cnt_d;
    end
  end

  assign bus.msg1_ready     = msg1_ready_s;
  assign bus.msg3_ready     = msg3_ready_s;
  assign bus.pipe_valid     = pipe_valid_q;
  assign bus.pipe_from_resp = from_resp_q;
  assign bus.pipe_type      = cur_type_q;
  assign bus.pipe_source    = cur_src_q;
  assign bus.pipe_tag       = cur_tag_q;
  assign bus.pipe_data      = cur_data_q;
  assign bus.msg2_valid     = msg2_valid_q;
  assign bus.msg2_type      = msg2_type_q;
  assign bus.msg2_dest      = msg2_dest_q;
  assign bus.msg2_tag       = msg2_tag_q;
  assign bus.cur_msg_state  = state_q;
  assign bus.cur_msg_type   = cur_type_q;
  assign bus.cur_msg_source = cur_src_q;
  assign bus.cur_msg_tag    = cur_tag_q;
  assign bus.ack_wait_cnt   = ack_cnt_q;
endmodule

// File: tb/tb_l2_msg_sched.sv
// Directed bench for l2_msg_sched: accepted messages are pushed to a scoreboard and
// compared when the scheduler presents them to the pipeline.
module tb_l2_msg_sched;
  logic clk;
  logic rst;
  int checks;
  int failures;

  typedef struct packed {
    logic [7:0]  typ;
    logic [5:0]  src;
    logic [25:0] tag;
    logic [63:0] data;
    logic        resp;
  } exp_t;

  exp_t exp_q[$];

  l2_msg_sched_if #(.TYPE_W(8), .SRC_W(6), .TAG_W(26), .DATA_W(64)) bus ();

  l2_msg_sched #(.TYPE_W(8), .SRC_W(6), .TAG_W(26), .DATA_W(64), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request until accepted (bounded), then record it as expected pipeline traffic.
  task automatic do_msg1(input logic [7:0] t, input logic [5:0] s, input logic [25:0] g,
                         input logic [63:0] d);
    logic ok;
    exp_t e;
    ok = 1'b0;
    bus.msg1_valid = 1'b1; bus.msg1_type = t; bus.msg1_source = s;
    bus.msg1_tag = g; bus.msg1_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.msg1_ready) ok = 1'b1;
      tick();
    end
    bus.msg1_valid = 1'b0;
    chk("msg1_accept", 64'(ok), 64'd1);
    if (ok) begin
      e = '{typ: t, src: s, tag: g, data: d, resp: 1'b0};
      exp_q.push_back(e);
    end
  endtask

  task automatic do_msg3(input logic [7:0] t, input logic [5:0] s, input logic [25:0] g,
                         input logic [63:0] d);
    logic ok;
    exp_t e;
    ok = 1'b0;
    bus.msg3_valid = 1'b1; bus.msg3_type = t; bus.msg3_source = s;
    bus.msg3_tag = g; bus.msg3_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.msg3_ready) ok = 1'b1;
      tick();
    end
    bus.msg3_valid = 1'b0;
    chk("msg3_accept", 64'(ok), 64'd1);
    if (ok) begin
      e = '{typ: t, src: s, tag: g, data: d, resp: 1'b1};
      exp_q.push_back(e);
    end
  endtask

  task automatic check_issue(input string tag);
    exp_t e;
    chk({tag, "_pipe_valid"}, 64'(bus.pipe_valid), 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_type"}, 64'(bus.pipe_type), 64'(e.typ));
      chk({tag, "_src"}, 64'(bus.pipe_source), 64'(e.src));
      chk({tag, "_tag"}, 64'(bus.pipe_tag), 64'(e.tag));
      chk({tag, "_data"}, bus.pipe_data, e.data);
      chk({tag, "_from_resp"}, 64'(bus.pipe_from_resp), 64'(e.resp));
    end
  endtask

  initial begin
    exp_t e;
    checks = 0;
    failures = 0;
    rst = 1'b0;
    bus.msg1_valid = 1'b0; bus.msg1_type = 8'd0; bus.msg1_source = 6'd0;
    bus.msg1_tag = 26'd0; bus.msg1_data = 64'd0;
    bus.msg3_valid = 1'b0; bus.msg3_type = 8'd0; bus.msg3_source = 6'd0;
    bus.msg3_tag = 26'd0; bus.msg3_data = 64'd0;
    bus.pipe_ready = 1'b0; bus.pipe_fwd_req = 1'b0;
    bus.pipe_fwd_type = 8'd0; bus.pipe_fwd_dest = 6'd0;
    bus.msg2_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_state", 64'(bus.cur_msg_state), 64'd0);
    chk("rst_pipe_valid", 64'(bus.pipe_valid), 64'd0);
    chk("rst_msg2_valid", 64'(bus.msg2_valid), 64'd0);
    chk("rst_msg1_ready", 64'(bus.msg1_ready), 64'd0);
    chk("rst_msg3_ready", 64'(bus.msg3_ready), 64'd0);
    chk("rst_ack_cnt", 64'(bus.ack_wait_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_msg3_ready", 64'(bus.msg3_ready), 64'd1);

    // Simple request, no forward
    bus.pipe_ready = 1'b1;
    do_msg1(8'h02, 6'd1, 26'h12345, 64'h1111);
    check_issue("simple");
    chk("simple_state_issue", 64'(bus.cur_msg_state), 64'd1);
    tick();
    chk("simple_pipe_valid_drop", 64'(bus.pipe_valid), 64'd0);
    chk("simple_state_idle", 64'(bus.cur_msg_state), 64'd0);
    chk("simple_no_msg2", 64'(bus.msg2_valid), 64'd0);

    // Forward flow with msg2 back-pressure
    bus.pipe_fwd_req = 1'b1; bus.pipe_fwd_type = 8'h12; bus.pipe_fwd_dest = 6'd5;
    do_msg1(8'h05, 6'd3, 26'hABC, 64'h55);
    check_issue("fwd");
    tick();
    chk("fwd_state_send", 64'(bus.cur_msg_state), 64'd2);
    chk("fwd_pipe_valid_drop", 64'(bus.pipe_valid), 64'd0);
    bus.pipe_ready = 1'b0; bus.pipe_fwd_req = 1'b0;
    bus.pipe_fwd_type = 8'h00; bus.pipe_fwd_dest = 6'd0;
    for (int i = 0; i < 3; i++) begin
      chk("fwd_msg2_valid", 64'(bus.msg2_valid), 64'd1);
      chk("fwd_msg2_type", 64'(bus.msg2_type), 64'h12);
      chk("fwd_msg2_dest", 64'(bus.msg2_dest), 64'd5);
      chk("fwd_msg2_tag", 64'(bus.msg2_tag), 64'hABC);
      if (i < 2) tick();
    end
    bus.msg2_ready = 1'b1;
    tick();
    bus.msg2_ready = 1'b0;
    chk("fwd_state_wait", 64'(bus.cur_msg_state), 64'd3);
    chk("fwd_msg2_drop", 64'(bus.msg2_valid), 64'd0);
    chk("fwd_ack_clear", 64'(bus.ack_wait_cnt), 64'd0);
    bus.msg1_valid = 1'b1; bus.msg1_tag = 26'h3FF;
    #1;
    chk("wait_msg1_blocked", 64'(bus.msg1_ready), 64'd0);
    chk("wait_msg3_ready", 64'(bus.msg3_ready), 64'd1);
    repeat (5) tick();
    chk("wait_ack_5", 64'(bus.ack_wait_cnt), 64'd5);
    repeat (4) tick();

    // Ack completion: accepted at the 10th edge spent in WAIT_ACK
    do_msg3(8'h16, 6'd5, 26'hABC, 64'hDEADBEEF);
    chk("ack_cnt_10", 64'(bus.ack_wait_cnt), 64'd10);
    chk("ack_state_issue", 64'(bus.cur_msg_state), 64'd1);
    check_issue("ack");
    bus.msg1_valid = 1'b0;
    bus.pipe_ready = 1'b1;
    tick();
    chk("ack_state_idle", 64'(bus.cur_msg_state), 64'd0);
    chk("ack_no_msg2", 64'(bus.msg2_valid), 64'd0);

    // Starvation: both channels valid continuously, 4 responses then 1 request
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) e = '{typ: 8'h02, src: 6'd1, tag: 26'h111, data: 64'hAAAA, resp: 1'b0};
      else            e = '{typ: 8'h16, src: 6'd2, tag: 26'h333, data: 64'hBBBB, resp: 1'b1};
      exp_q.push_back(e);
    end
    bus.msg1_type = 8'h02; bus.msg1_source = 6'd1; bus.msg1_tag = 26'h111; bus.msg1_data = 64'hAAAA;
    bus.msg3_type = 8'h16; bus.msg3_source = 6'd2; bus.msg3_tag = 26'h333; bus.msg3_data = 64'hBBBB;
    bus.msg1_valid = 1'b1; bus.msg3_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.pipe_valid) check_issue("starve");
    end
    bus.msg1_valid = 1'b0; bus.msg3_valid = 1'b0;
    chk("starve_sb_drained", 64'(exp_q.size()), 64'd0);
    tick();
    chk("starve_state_idle", 64'(bus.cur_msg_state), 64'd0);

    // Ack counter saturation
    bus.pipe_fwd_req = 1'b1; bus.pipe_fwd_type = 8'h12; bus.pipe_fwd_dest = 6'd7;
    bus.msg2_ready = 1'b1;
    do_msg1(8'h05, 6'd3, 26'h77, 64'h0);
    check_issue("sat");
    tick();
    chk("sat_state_send", 64'(bus.cur_msg_state), 64'd2);
    tick();
    chk("sat_state_wait", 64'(bus.cur_msg_state), 64'd3);
    bus.pipe_ready = 1'b0; bus.pipe_fwd_req = 1'b0; bus.msg2_ready = 1'b0;
    repeat (300) tick();
    chk("sat_ack_255", 64'(bus.ack_wait_cnt), 64'd255);
    chk("sat_still_wait", 64'(bus.cur_msg_state), 64'd3);
    do_msg3(8'h16, 6'd7, 26'h77, 64'h9);
    check_issue("sat_ack");
    bus.pipe_ready = 1'b1;
    tick();
    chk("sat_state_idle", 64'(bus.cur_msg_state), 64'd0);

    // Reset asserted while msg2 is pending
    bus.pipe_fwd_req = 1'b1; bus.pipe_fwd_type = 8'h12; bus.pipe_fwd_dest = 6'd9;
    do_msg1(8'h05, 6'd3, 26'h99, 64'h1);
    check_issue("rstm");
    tick();
    chk("rstm_msg2_valid", 64'(bus.msg2_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstm_msg2_valid_0", 64'(bus.msg2_valid), 64'd0);
    chk("rstm_pipe_valid_0", 64'(bus.pipe_valid), 64'd0);
    chk("rstm_state_0", 64'(bus.cur_msg_state), 64'd0);
    chk("rstm_msg2_tag_0", 64'(bus.msg2_tag), 64'd0);
    chk("rstm_cur_tag_0", 64'(bus.cur_msg_tag), 64'd0);
    chk("rstm_pipe_data_0", bus.pipe_data, 64'd0);
    chk("rstm_msg3_ready_0", 64'(bus.msg3_ready), 64'd0);
    bus.pipe_fwd_req = 1'b0; bus.pipe_ready = 1'b0; bus.msg2_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstm_post_no_msg2", 64'(bus.msg2_valid), 64'd0);
      chk("rstm_post_idle", 64'(bus.cur_msg_state), 64'd0);
    end
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
